ddr3_video_reader: RTL and testbench
====================================

// Module: ddr3_video_reader
// PURPOSE
//  Downstream consumer of the DDR3 two-port frame buffer read FIFO. Generates raster timing
//  (HS/VS/DE) in the pixel clock domain and pops one 32-bit FIFO word per active pixel.
//  Pulses rd_load once per frame so the FIFO adapter rewinds to the frame start address.
//  Drives the RGB888 stream into the display/HDMI encoder stage.
// PARAMETERS
//  H_ACTIVE 1280  active pixels per line
//  H_FP     110   horizontal front porch (pixels)
//  H_SYNC   40    horizontal sync width
//  H_BP     220   horizontal back porch
//  V_ACTIVE 720   active lines per frame
//  V_FP     5     vertical front porch (lines)
//  V_SYNC   5     vertical sync width
//  V_BP     20    vertical back porch
//  SYNC_POL 1     1: HS/VS active-high; 0: active-low
// PORTS
//  clk          in  1   pixel clock; same clock as the read FIFO's rd_clk
//  rst          in  1   synchronous, active-high reset
//  calib_done   in  1   DDR3 init done, already synchronised to clk
//  rd_load      out 1   one-cycle pulse: adapter rewinds its read address
//  rdfifo_rden  out 1   read FIFO pop; data is valid on the cycle after rden
//  rdfifo_dout  in  32  FIFO word; pixel = [23:0] (R[23:16] G[15:8] B[7:0])
//  vid_de       out 1   data enable
//  vid_hs       out 1   horizontal sync (polarity set by SYNC_POL)
//  vid_vs       out 1   vertical sync (polarity set by SYNC_POL)
//  vid_rgb      out 24  pixel data; 0 when vid_de=0
//  frame_start  out 1   one-cycle pulse aligned with the first vid_de of each frame
// BEHAVIOUR
//  - Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
//  - Reset values: all outputs deasserted. HS/VS sit at their inactive level, rgb=0, rd_load=0.
//  - Counters: hcnt in 0..H_TOTAL-1, vcnt in 0..V_TOTAL-1, with H_TOTAL = sum of the H_* parameters.
//    vcnt advances when hcnt wraps. Order per line: active, FP, sync, BP. Frame order is the same.
//  - Control FSM, states IDLE -> RUN:
//    - IDLE: hcnt=0, vcnt=V_ACTIVE (blanking), all outputs inactive.
//    - IDLE -> RUN on calib_done=1.
//    - RUN -> IDLE in the same cycle that calib_done drops. Outputs are blanked on the next cycle, even mid-line.
//  - Active region: active = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE).
//  - Pipeline, counters at cycle t:
//    - rdfifo_rden = registered active, valid at t+1.
//    - FIFO data is valid at t+2.
//    - vid_de/hs/vs are delayed 2 cycles, so they align with the data at t+2.
//  - vid_rgb = vid_de ? rdfifo_dout[23:0] : 0. Bits [31:24] are ignored.
//  - rd_load: one-cycle pulse when RUN && hcnt==0 && vcnt==V_ACTIVE+V_FP (start of VS).
//    This gives the adapter at least V_SYNC+V_BP lines to prefetch.
//    The first pulse occurs before the first active line after IDLE->RUN.
//  - Exactly H_ACTIVE*V_ACTIVE rden pulses occur between consecutive rd_load pulses.
//  - An empty FIFO is not detected here; the adapter guarantees prefetch.
//  - Reset asserted mid-line: all outputs take reset values on the next edge and the FSM returns to IDLE.
// CONFIGURATION
//  - COLOR_BAR_EN defined:
//    - Adds input test_mode (1 bit).
//    - test_mode=1: rdfifo_rden is held 0 and rd_load is suppressed.
//    - vid_rgb shows 8 vertical bars, each H_ACTIVE/8 wide: white, yellow, cyan, green, magenta, red, blue, black.
//    - Timing is unchanged.
//  - COLOR_BAR_EN undefined: no test_mode port; FIFO data is always used.
// STRUCTURE
//  - Package ddr3_video_pkg: the default 720p timing constants, and H_TOTAL/V_TOTAL derivation functions.
//  - Sub-module video_timing_gen: hcnt/vcnt counters plus the raw active/hs/vs/load-point decode.
//    The top level adds the IDLE/RUN FSM, the 2-stage alignment pipeline and the pixel mux.
// TESTING (use the small timing: H 8/2/2/2, V 4/1/1/1)
//  1 Reset held, then released with calib_done=0 -> all outputs inactive for 1000 cycles; rden=0.
//  2 calib_done rises -> rd_load pulses before any rden.
//    -> Exactly 32 rden pulses per frame, in 4 bursts of 8.
//    -> rd_load is 1 cycle wide, once per frame (every 14*7=98 cycles).
//  3 FIFO model returns an incrementing word one cycle after rden.
//    -> vid_rgb is 0,1,2,... with vid_de high on exactly those cycles.
//    -> frame_start coincides with pixel 0.
//  4 rdfifo_dout = 0xAA123456 -> vid_rgb = 0x123456.
//    -> With SYNC_POL=0: HS low for 2 cycles per line and VS low for 1 line.
//  5 calib_done dropped mid-line (hcnt=3, vcnt=1) -> next cycle de/rden are 0 and the FSM is IDLE.
//    -> On re-raise, a fresh rd_load is issued before the next active line.
//  6 COLOR_BAR_EN with test_mode=1 -> rden is never asserted.
//    -> Bars at hcnt 0 and 7 read 0xFFFFFF and 0x000000.

Source files
------------

// File: rtl/ddr3_video_pkg.sv
// Default 720p raster timing, FSM state type and colour-bar palette shared by the video reader.
package ddr3_video_pkg;

   localparam int DEF_H_ACTIVE = 1280;
   localparam int DEF_H_FP     = 110;
   localparam int DEF_H_SYNC   = 40;
   localparam int DEF_H_BP     = 220;
   localparam int DEF_V_ACTIVE = 720;
   localparam int DEF_V_FP     = 5;
   localparam int DEF_V_SYNC   = 5;
   localparam int DEF_V_BP     = 20;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic int h_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int v_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = 24'hFFFFFF;
         3'd1:    c = 24'hFFFF00;
         3'd2:    c = 24'h00FFFF;
         3'd3:    c = 24'h00FF00;
         3'd4:    c = 24'hFF00FF;
         3'd5:    c = 24'hFF0000;
         3'd6:    c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ddr3_video_reader_if.sv
// Pixel-clock bundle: read-FIFO pop/rewind handshake plus the RGB888 video stream.
interface ddr3_video_reader_if;
   logic        rd_load;
   logic        rdfifo_rden;
   logic [31:0] rdfifo_dout;
   logic        vid_de;
   logic        vid_hs;
   logic        vid_vs;
   logic [23:0] vid_rgb;
   logic        frame_start;

   modport master (
      output rd_load, rdfifo_rden, vid_de, vid_hs, vid_vs, vid_rgb, frame_start,
      input  rdfifo_dout
   );

   modport slave (
      input  rd_load, rdfifo_rden, vid_de, vid_hs, vid_vs, vid_rgb, frame_start,
      output rdfifo_dout
   );
endinterface

// File: rtl/video_timing_gen.sv
// Raster counters and raw (unaligned) decode of active area, syncs, FIFO rewind point and bar index.
module video_timing_gen
   import ddr3_video_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run_i,
   output logic       active_o,
   output logic       hsync_o,
   output logic       vsync_o,
   output logic       load_pt_o,
   output logic       first_px_o,
   output logic [2:0] bar_o
);
   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [VW-1:0] vcnt_q, vcnt_d;

   always_comb begin
      hcnt_d = hcnt_q + 1'b1;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end
   end

   // Parked in vertical blanking so a restart always passes the rewind point first.
   always_ff @(posedge clk) begin
      if (rst || !run_i) begin
         hcnt_q <= '0;
         vcnt_q <= V_ACT;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   assign active_o   = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
   assign hsync_o    = (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
   assign vsync_o    = (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);
   assign load_pt_o  = (hcnt_q == '0) && (vcnt_q == VS_FIRST);
   assign first_px_o = (hcnt_q == '0) && (vcnt_q == '0);
   assign bar_o      = 3'(32'(hcnt_q) / BAR_W);

endmodule

// File: rtl/ddr3_video_reader.sv
// Raster reader: pops the DDR3 read FIFO once per active pixel and emits HS/VS/DE/RGB888.
// Define COLOR_BAR_EN to add a test_mode input that replaces FIFO data with 8 colour bars.
module ddr3_video_reader
   import ddr3_video_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic calib_done,
`ifdef COLOR_BAR_EN
   input  logic test_mode,
`endif
   ddr3_video_reader_if.master vid
);
   // state   | meaning
   // ST_IDLE | DDR3 not ready; counters parked at (0, V_ACTIVE), outputs blanked
   // ST_RUN  | raster running; FIFO popped on every active pixel

   state_e      state_q, state_d;
   logic        run;
   logic        active, hsync, vsync, load_pt, first_px;
   logic [2:0]  bar;
   logic        tm;
   logic        rden_q, load_q;
   logic [1:0]  de_q, hs_q, vs_q, fs_q;
   logic [23:0] pix;

   always_comb begin
      state_d = state_q;
      run     = 1'b0;
      if (state_q == ST_IDLE) begin
         if (calib_done) state_d = ST_RUN;
      end else if (calib_done) begin
         run = 1'b1;
      end else begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   video_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk        (clk),
      .rst        (rst),
      .run_i      (run),
      .active_o   (active),
      .hsync_o    (hsync),
      .vsync_o    (vsync),
      .load_pt_o  (load_pt),
      .first_px_o (first_px),
      .bar_o      (bar)
   );

`ifdef COLOR_BAR_EN
   assign tm = test_mode;
`else
   assign tm = 1'b0;
`endif

   // Stage 0 pops the FIFO; video controls take one more stage to meet the registered FIFO data.
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         rden_q <= 1'b0;
         load_q <= 1'b0;
         de_q   <= '0;
         hs_q   <= '0;
         vs_q   <= '0;
         fs_q   <= '0;
      end else begin
         rden_q <= active && !tm;
         load_q <= load_pt && !tm;
         de_q   <= {de_q[0], active};
         hs_q   <= {hs_q[0], hsync};
         vs_q   <= {vs_q[0], vsync};
         fs_q   <= {fs_q[0], first_px};
      end
   end

`ifdef COLOR_BAR_EN
   logic [2:0] bar1_q, bar2_q;
   logic       unused_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         bar1_q <= '0;
         bar2_q <= '0;
      end else begin
         bar1_q <= bar;
         bar2_q <= bar1_q;
      end
   end

   assign pix       = tm ? bar_color(bar2_q) : vid.rdfifo_dout[23:0];
   assign unused_ok = &{1'b0, vid.rdfifo_dout[31:24]};
`else
   logic unused_ok;
   assign pix       = vid.rdfifo_dout[23:0];
   assign unused_ok = &{1'b0, vid.rdfifo_dout[31:24], bar};
`endif

   assign vid.rdfifo_rden = rden_q;
   assign vid.rd_load     = load_q;
   assign vid.vid_de      = de_q[1];
   assign vid.vid_hs      = hs_q[1] ~^ SYNC_POL;
   assign vid.vid_vs      = vs_q[1] ~^ SYNC_POL;
   assign vid.frame_start = fs_q[1];
   assign vid.vid_rgb     = de_q[1] ? pix : 24'h0;

endmodule

// File: tb/tb_ddr3_video_reader.sv
// Directed bench for ddr3_video_reader on a 14x7 raster (H 8/2/2/2, V 4/1/1/1, active-low syncs).
module tb_ddr3_video_reader;
   import ddr3_video_pkg::*;

   typedef struct {
      int          k;
      logic [5:0]  flags;   // {rden, rd_load, de, hs, vs, frame_start}
      logic [23:0] rgb;
   } vec_t;

   localparam int          NV       = 22;
   localparam logic [29:0] IDLE_OBS = {6'b000110, 24'h0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic calib_done = 1'b0;
`ifdef COLOR_BAR_EN
   logic test_mode = 1'b0;
`endif

   ddr3_video_reader_if bus();

   ddr3_video_reader #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .calib_done (calib_done),
`ifdef COLOR_BAR_EN
      .test_mode  (test_mode),
`endif
      .vid        (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int kc    = 0;

   // FIFO/adapter model: rewinds on rd_load, returns a word on the edge after rden.
   logic        fifo_const = 1'b0;
   logic [23:0] fifo_cnt   = 24'h0;
   always @(posedge clk) begin
      if (bus.rd_load) begin
         fifo_cnt <= 24'h0;
      end else if (bus.rdfifo_rden) begin
         bus.rdfifo_dout <= fifo_const ? 32'hAA12_3456 : {8'h5A, fifo_cnt};
         fifo_cnt        <= fifo_cnt + 24'd1;
      end
   end

   function automatic logic [29:0] obs();
      return {bus.rdfifo_rden, bus.rd_load, bus.vid_de, bus.vid_hs, bus.vid_vs,
              bus.frame_start, bus.vid_rgb};
   endfunction

   task automatic step();
      @(negedge clk);
      kc++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      vec_t vt[NV];
      int   first_load, first_rden, load_k1, load_k2, n_load;
      int   burst_len, n_burst, cnt_a, cnt_b, cnt_c, viol;
      logic seen;

      // k counts cycles after the edge that moves the FSM to RUN; counters then sit at (0,4).
      vt[0]  = '{0,   6'b000110, 24'd0};
      vt[1]  = '{12,  6'b000010, 24'd0};
      vt[2]  = '{13,  6'b000010, 24'd0};
      vt[3]  = '{14,  6'b000110, 24'd0};
      vt[4]  = '{15,  6'b010110, 24'd0};
      vt[5]  = '{16,  6'b000100, 24'd0};
      vt[6]  = '{26,  6'b000000, 24'd0};
      vt[7]  = '{29,  6'b000100, 24'd0};
      vt[8]  = '{30,  6'b000110, 24'd0};
      vt[9]  = '{43,  6'b100110, 24'd0};
      vt[10] = '{44,  6'b101111, 24'd0};
      vt[11] = '{45,  6'b101110, 24'd1};
      vt[12] = '{50,  6'b101110, 24'd6};
      vt[13] = '{51,  6'b001110, 24'd7};
      vt[14] = '{52,  6'b000110, 24'd0};
      vt[15] = '{58,  6'b101110, 24'd8};
      vt[16] = '{93,  6'b001110, 24'd31};
      vt[17] = '{94,  6'b000110, 24'd0};
      vt[18] = '{113, 6'b010110, 24'd0};
      vt[19] = '{114, 6'b000100, 24'd0};
      vt[20] = '{142, 6'b101111, 24'd0};
      vt[21] = '{143, 6'b101110, 24'd1};

      // Reset, then a long idle with calib_done low.
      repeat (4) step();
      chk("rst_outputs", 32'(obs()), 32'(IDLE_OBS));
      chk("rst_fsm", 32'(dut.state_q), 32'(ST_IDLE));
      rst  = 1'b0;
      viol = 0;
      cnt_a = 0;
      for (int c = 0; c < 1000; c++) begin
         step();
         if (obs() != IDLE_OBS) viol++;
         if (bus.rdfifo_rden) cnt_a++;
      end
      chk("idle_outputs", 32'(viol), 32'd0);
      chk("idle_rden", 32'(cnt_a), 32'd0);

      // Two frames of incrementing FIFO data against the vector table.
      calib_done = 1'b1;
      kc = -1;
      n_load = 0; first_load = -1; first_rden = -1; load_k1 = -1; load_k2 = -1;
      burst_len = 0; n_burst = 0; cnt_a = 0;
      for (int c = 0; c < 200; c++) begin
         step();
         for (int i = 0; i < NV; i++)
            if (vt[i].k == kc)
               chk($sformatf("vec_k%0d", kc), 32'(obs()), 32'({vt[i].flags, vt[i].rgb}));
         if (bus.rd_load) begin
            n_load++;
            if (n_load == 1) load_k1 = kc;
            if (n_load == 2) load_k2 = kc;
            if (first_load < 0) first_load = kc;
         end
         if (bus.rdfifo_rden && first_rden < 0) first_rden = kc;
         if (n_load == 1) begin
            if (bus.rdfifo_rden) begin
               cnt_a++;
               burst_len++;
            end else if (burst_len != 0) begin
               n_burst++;
               chk("burst_len", 32'(burst_len), 32'd8);
               burst_len = 0;
            end
         end
      end
      chk("load_count", 32'(n_load), 32'd2);
      chk("load_period", 32'(load_k2 - load_k1), 32'd98);
      chk("rden_per_frame", 32'(cnt_a), 32'd32);
      chk("burst_count", 32'(n_burst), 32'd4);
      chk("load_before_rden", 32'(first_load >= 0 && first_load < first_rden), 32'd1);

      // Constant FIFO word: upper byte dropped, sync widths over one whole frame.
      fifo_const = 1'b1;
      cnt_a = 0; cnt_b = 0; cnt_c = 0; viol = 0;
      for (int c = 0; c < 98; c++) begin
         step();
         if (!bus.vid_hs) cnt_a++;
         if (!bus.vid_vs) cnt_b++;
         if (bus.vid_de) begin
            cnt_c++;
            if (bus.vid_rgb != 24'h123456) viol++;
         end else if (bus.vid_rgb != 24'h0) begin
            viol++;
         end
      end
      chk("hs_low_cycles", 32'(cnt_a), 32'd14);
      chk("vs_low_cycles", 32'(cnt_b), 32'd14);
      chk("de_cycles", 32'(cnt_c), 32'd32);
      chk("rgb_const", 32'(viol), 32'd0);

      // Drop calib_done while counters are at hcnt=3, vcnt=1.
      while (kc < 353) step();
      chk("pre_drop_de", 32'(bus.vid_de), 32'd1);
      chk("pre_drop_rden", 32'(bus.rdfifo_rden), 32'd1);
      calib_done = 1'b0;
      step();
      chk("drop_outputs", 32'(obs()), 32'(IDLE_OBS));
      chk("drop_fsm", 32'(dut.state_q), 32'(ST_IDLE));
      repeat (20) step();
      chk("drop_hold", 32'(obs()), 32'(IDLE_OBS));
      fifo_const = 1'b0;

      // Re-raise: fresh rewind precedes the first pop, data restarts at word 0.
      calib_done = 1'b1;
      first_load = -1; first_rden = -1; seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (bus.rd_load && first_load < 0) first_load = c;
         if (bus.rdfifo_rden && first_rden < 0) first_rden = c;
         if (bus.frame_start && !seen) begin
            seen = 1'b1;
            chk("restart_rgb", 32'(bus.vid_rgb), 32'd0);
         end
      end
      chk("restart_load_k", 32'(first_load), 32'd15);
      chk("restart_rden_k", 32'(first_rden), 32'd43);
      chk("restart_fs_seen", 32'(seen), 32'd1);

      // Synchronous reset in the middle of an active line.
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         step();
         if (bus.vid_de) seen = 1'b1;
      end
      chk("midline_de_seen", 32'(seen), 32'd1);
      rst = 1'b1;
      step();
      chk("midline_rst_outputs", 32'(obs()), 32'(IDLE_OBS));
      chk("midline_rst_fsm", 32'(dut.state_q), 32'(ST_IDLE));
      rst = 1'b0;

`ifdef COLOR_BAR_EN
      test_mode = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         step();
         if (bus.frame_start) seen = 1'b1;
      end
      chk("bar_fs_seen", 32'(seen), 32'd1);
      chk("bar0", 32'({bus.vid_de, bus.vid_rgb}), 32'({1'b1, 24'hFFFFFF}));
      step();
      chk("bar1", 32'({bus.vid_de, bus.vid_rgb}), 32'({1'b1, 24'hFFFF00}));
      repeat (6) step();
      chk("bar7", 32'({bus.vid_de, bus.vid_rgb}), 32'({1'b1, 24'h000000}));
      cnt_a = 0; cnt_b = 0;
      for (int c = 0; c < 98; c++) begin
         step();
         if (bus.rdfifo_rden) cnt_a++;
         if (bus.rd_load) cnt_b++;
      end
      chk("bar_rden", 32'(cnt_a), 32'd0);
      chk("bar_load", 32'(cnt_b), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
